// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the FIFO read-side controller.
package fifo_pkg;

  localparam int unsigned ADDR_W_DEF      = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned AE_TH_DEF       = 2;

  // Helpers work on a fixed wide vector; callers zero-extend and truncate to their width.
  localparam int unsigned PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin = gray;
    for (int i = 1; i < int'(PTR_MAX_W); i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module gray_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < int'(STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(STAGES); i++) begin
      if (rst) sync_q[i] <= '0;
      else     sync_q[i] <= sync_d[i];
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of an async FIFO: read pointer, empty/count status and
// underflow detection against a synchronised Gray write pointer.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned AE_TH       = AE_TH_DEF
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              fifo_empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              rd_valid,
  output logic              underflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wq;

  gray_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk  (rd_clk),
    .rst  (rd_rst),
    .din  (wr_ptr_gray),
    .dout (wq)
  );

  logic [PTR_W-1:0] rd_bin_q,       rd_bin_d;
  logic [PTR_W-1:0] rd_ptr_gray_q,  rd_ptr_gray_d;
  logic [PTR_W-1:0] rd_count_q,     rd_count_d;
  logic             fifo_empty_q,   fifo_empty_d;
  logic             almost_empty_q, almost_empty_d;
  logic             rd_valid_q,     rd_valid_d;
  logic             underflow_q,    underflow_d;
  logic             rd_accept_c;

  // Status is computed from the post-increment pointer so it moves on the read edge itself.
  always_comb begin
    rd_accept_c    = rd_en & ~fifo_empty_q;
    rd_bin_d       = rd_bin_q + PTR_W'(rd_accept_c);
    rd_ptr_gray_d  = PTR_W'(bin2gray(PTR_MAX_W'(rd_bin_d)));
    fifo_empty_d   = (rd_ptr_gray_d == wq);
    rd_count_d     = PTR_W'(gray2bin(PTR_MAX_W'(wq))) - rd_bin_d;
    almost_empty_d = (PTR_MAX_W'(rd_count_d) <= AE_TH);
    rd_valid_d     = rd_accept_c;
    underflow_d    = rd_en & fifo_empty_q;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_bin_q       <= '0;
      rd_ptr_gray_q  <= '0;
      rd_count_q     <= '0;
      fifo_empty_q   <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_valid_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      rd_bin_q       <= rd_bin_d;
      rd_ptr_gray_q  <= rd_ptr_gray_d;
      rd_count_q     <= rd_count_d;
      fifo_empty_q   <= fifo_empty_d;
      almost_empty_q <= almost_empty_d;
      rd_valid_q     <= rd_valid_d;
      underflow_q    <= underflow_d;
    end
  end

  assign rd_addr      = rd_bin_q[ADDR_W-1:0];
  assign rd_ptr_gray  = rd_ptr_gray_q;
  assign rd_count     = rd_count_q;
  assign fifo_empty   = fifo_empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_valid     = rd_valid_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl (ADDR_W=4, SYNC_STAGES=2, AE_TH=2).
module tb_fifo_rd_ctrl;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic       rd_en;
  logic [4:0] wr_ptr_gray;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr_gray;
  logic       fifo_empty;
  logic       almost_empty;
  logic [4:0] rd_count;
  logic       rd_valid;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  fifo_rd_ctrl #(
    .ADDR_W      (4),
    .SYNC_STAGES (2),
    .AE_TH       (2)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .rd_en        (rd_en),
    .wr_ptr_gray  (wr_ptr_gray),
    .rd_addr      (rd_addr),
    .rd_ptr_gray  (rd_ptr_gray),
    .fifo_empty   (fifo_empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .rd_valid     (rd_valid),
    .underflow    (underflow)
  );

  always #5 rd_clk = ~rd_clk;

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic test_reset();
    rd_rst = 1'b1; rd_en = 1'b1; wr_ptr_gray = 5'd0;
    repeat (3) tick();
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", fifo_empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae: got %b want 1", almost_empty); end
    checks++; if (rd_ptr_gray !== 5'd0) begin errors++; $display("FAIL rst_ptr: got %0d want 0", rd_ptr_gray); end
    checks++; if (rd_count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", rd_count); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow: got %b want 0", underflow); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", rd_valid); end
    rd_rst = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_sync_latency();
    wr_ptr_gray = 5'b00010;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (fifo_empty !== (e < 3)) begin errors++; $display("FAIL lat_empty edge %0d: got %b want %b", e, fifo_empty, (e < 3)); end
    end
    checks++; if (rd_count !== 5'd3) begin errors++; $display("FAIL lat_count: got %0d want 3", rd_count); end
    checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL lat_ae: got %b want 0", almost_empty); end
  endtask

  task automatic test_reads();
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_addr !== 4'(i)) begin errors++; $display("FAIL rd_addr %0d: got %0d want %0d", i, rd_addr, i); end
      tick();
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid %0d: got %b want 1", i, rd_valid); end
      checks++; if (rd_count !== 5'(2 - i)) begin errors++; $display("FAIL rd_count %0d: got %0d want %0d", i, rd_count, 2 - i); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rd_ae %0d: got %b want 1", i, almost_empty); end
      checks++; if (fifo_empty !== (i == 2)) begin errors++; $display("FAIL rd_empty %0d: got %b want %b", i, fifo_empty, (i == 2)); end
    end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_pulse %0d: got %b want 1", i, underflow); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL uf_valid %0d: got %b want 0", i, rd_valid); end
      checks++; if (rd_ptr_gray !== 5'd2) begin errors++; $display("FAIL uf_ptr %0d: got %0d want 2", i, rd_ptr_gray); end
    end
    rd_en = 1'b0;
    tick();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b want 0", underflow); end
  endtask

  // Drains from rd_bin=3 up to 30, then wraps the write side round to 2.
  task automatic test_wrap();
    wr_ptr_gray = 5'd26;  // gray(19)
    repeat (3) tick();
    checks++; if (rd_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", rd_count); end
    checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL full_ae: got %b want 0", almost_empty); end
    rd_en = 1'b1;
    repeat (16) tick();
    rd_en = 1'b0;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL drain16_empty: got %b want 1", fifo_empty); end
    checks++; if (rd_ptr_gray !== 5'd26) begin errors++; $display("FAIL drain16_ptr: got %0d want 26", rd_ptr_gray); end
    wr_ptr_gray = 5'd17;  // gray(30)
    repeat (3) tick();
    checks++; if (rd_count !== 5'd11) begin errors++; $display("FAIL pre30_count: got %0d want 11", rd_count); end
    rd_en = 1'b1;
    repeat (11) tick();
    rd_en = 1'b0;
    checks++; if (rd_ptr_gray !== 5'd17) begin errors++; $display("FAIL at30_ptr: got %0d want 17", rd_ptr_gray); end
    wr_ptr_gray = 5'd3;   // gray(2), wrapped
    repeat (3) tick();
    checks++; if (rd_count !== 5'd4) begin errors++; $display("FAIL wrap_count: got %0d want 4", rd_count); end
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL wrap_nonempty: got %b want 0", fifo_empty); end
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_addr;
      exp_addr = 4'((14 + i) % 16);
      checks++; if (rd_addr !== exp_addr) begin errors++; $display("FAIL wrap_addr %0d: got %0d want %0d", i, rd_addr, exp_addr); end
      tick();
      checks++; if (rd_count !== 5'(3 - i)) begin errors++; $display("FAIL wrap_cnt %0d: got %0d want %0d", i, rd_count, 3 - i); end
    end
    rd_en = 1'b0;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", fifo_empty); end
    checks++; if (rd_ptr_gray !== 5'd3) begin errors++; $display("FAIL wrap_ptr: got %0d want 3", rd_ptr_gray); end
    checks++; if (rd_addr !== 4'd2) begin errors++; $display("FAIL wrap_final_addr: got %0d want 2", rd_addr); end
  endtask

  task automatic test_mid_reset();
    wr_ptr_gray = 5'd4;   // gray(7): count 5 against rd_bin=2
    repeat (3) tick();
    checks++; if (rd_count !== 5'd5) begin errors++; $display("FAIL pre_rst_count: got %0d want 5", rd_count); end
    wr_ptr_gray = 5'd7;   // gray(5)
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mrst_empty: got %b want 1", fifo_empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL mrst_ae: got %b want 1", almost_empty); end
    checks++; if (rd_count !== 5'd0) begin errors++; $display("FAIL mrst_count: got %0d want 0", rd_count); end
    checks++; if (rd_ptr_gray !== 5'd0) begin errors++; $display("FAIL mrst_ptr: got %0d want 0", rd_ptr_gray); end
    checks++; if (rd_valid !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL mrst_flags: got valid=%b uf=%b want 0/0", rd_valid, underflow); end
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (fifo_empty !== (e < 3)) begin errors++; $display("FAIL post_rst_empty edge %0d: got %b want %b", e, fifo_empty, (e < 3)); end
    end
    checks++; if (rd_count !== 5'd5) begin errors++; $display("FAIL post_rst_count: got %0d want 5", rd_count); end
  endtask

  initial begin
    rd_rst = 1'b1; rd_en = 1'b0; wr_ptr_gray = 5'd0;
    test_reset();
    test_sync_latency();
    test_reads();
    test_underflow();
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width; FIFO depth is 2^ADDR_W entries.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchroniser flops on wr_ptr_gray; minimum 2.
REQ-003 Parameter AE_TH, default 2, almost-empty threshold in entries.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: rd_clk and rd_rst.
REQ-005 The ports SHALL be as follows:
- rd_clk  in  1  read-domain clock
- rd_rst  in  1  synchronous active-high reset
- rd_en  in  1  read request
- wr_ptr_gray  in  ADDR_W+1  Gray-coded write pointer from the write domain
- rd_addr  out  ADDR_W  memory read address (low bits of binary read pointer)
- rd_ptr_gray  out  ADDR_W+1  registered Gray read pointer, to the write domain
- fifo_empty  out  1  no readable entry
- almost_empty  out  1  rd_count <= AE_TH
- rd_count  out  ADDR_W+1  entries available, as seen in the read domain
- rd_valid  out  1  memory data valid this cycle
- underflow  out  1  one-cycle pulse on a rejected read

Function
REQ-006 wr_ptr_gray SHALL pass through a SYNC_STAGES-deep flop chain (wq) before any use.
REQ-007 A read SHALL be accepted only when rd_en=1 and fifo_empty=0.
- Accepted read: binary read pointer increments by 1.
- Otherwise: pointer holds.
REQ-008 Pointers SHALL be ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).
- rd_addr = rd_bin[ADDR_W-1:0].
- rd_ptr_gray = bin2gray(rd_bin), registered.
REQ-009 fifo_empty SHALL be registered as (bin2gray(rd_bin_next) == wq), where rd_bin_next is the post-increment pointer.
REQ-010 rd_count SHALL be registered as gray2bin(wq) - rd_bin_next, modulo 2^(ADDR_W+1); almost_empty SHALL be registered as (that value <= AE_TH).
REQ-011 fifo_empty, rd_count and almost_empty SHALL update on the same edge as the read pointer.
- An accepted read of the last entry asserts fifo_empty on that edge.
REQ-012 rd_valid SHALL be 1 exactly one cycle after each accepted read, to match one-cycle synchronous memory latency.
REQ-013 underflow SHALL pulse high for one cycle after an edge where rd_en=1 and fifo_empty=1.
- On that edge the pointer, rd_valid and rd_addr are unchanged.
REQ-014 Write-to-read latency: a wr_ptr_gray change held stable SHALL be reflected in fifo_empty and rd_count on the (SYNC_STAGES+1)th rd_clk edge.
REQ-015 rd_count SHALL never exceed 2^ADDR_W, given a legal write side.

Reset
REQ-016 While rd_rst=1 at a rising rd_clk edge, the block SHALL clear:
- rd_bin, rd_ptr_gray and all wq stages to 0
- rd_count=0, rd_valid=0, underflow=0
- and set fifo_empty=1, almost_empty=1.
REQ-017 rd_rst SHALL take priority over rd_en; a read requested during reset is neither accepted nor flagged as underflow.
REQ-018 After reset release, fifo_empty SHALL deassert no earlier than SYNC_STAGES+1 edges later, even when wr_ptr_gray is already non-zero.

Structure
REQ-019 Package fifo_pkg SHALL hold:
- the bin2gray and gray2bin functions, parametrised by width
- the default constants for ADDR_W, SYNC_STAGES and AE_TH.
REQ-020 The synchroniser SHALL be the sub-module gray_sync (parameters WIDTH and STAGES, synchronous reset).
- All remaining logic lives in fifo_rd_ctrl.

Verification (ADDR_W=4, SYNC_STAGES=2, AE_TH=2)
REQ-021 Hold rd_rst=1 and rd_en=1 for 3 cycles -> fifo_empty=1, almost_empty=1, rd_ptr_gray=0, rd_count=0, underflow=0, rd_valid=0.
REQ-022 Step wr_ptr_gray from 0 to 5'b00010 (binary 3) and hold -> fifo_empty falls on the 3rd edge; rd_count=3; almost_empty=0.
REQ-023 From REQ-022, hold rd_en=1 for 3 cycles:
- rd_addr shows 0, 1, 2
- rd_valid is high in the 3 following cycles
- almost_empty rises after the 1st read (count 2)
- fifo_empty rises on the 3rd read edge.
REQ-024 Hold rd_en=1 while fifo_empty=1 for 2 cycles -> underflow high for 2 cycles; rd_ptr_gray unchanged; rd_valid=0.
REQ-025 Wrap case: rd_bin=30 and synchronised wr binary 2 give rd_count=4. Then issue 4 reads:
- rd_addr shows 14, 15, 0, 1
- final rd_bin=2 and fifo_empty=1.
REQ-026 With rd_count=5, pulse rd_rst for 1 cycle while wr_ptr_gray holds gray(5) -> next edge matches the REQ-016 values; fifo_empty deasserts and rd_count=5 on the 3rd edge after release.
